// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor with EX-stage resolution: either a static
// stall-on-control scheme or a direct-mapped BTB with 2-bit counters.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int MODE     = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             bran_stall,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int TAG_W = XLEN - IDX_BITS - 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    else       return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic ctl;

  assign ctl = ex_valid && ((ex_opcode == OP_BRANCH) ||
                            (ex_opcode == OP_JAL)    ||
                            (ex_opcode == OP_JALR));

  assign redirect_pc = ex_taken ? ex_target
                                : ex_pc + {{(XLEN-3){1'b0}}, 3'd4};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ctl)   branch_cnt  <= sat_inc(branch_cnt);
      if (flush) mispred_cnt <= sat_inc(mispred_cnt);
    end
  end

  generate
    if (MODE == 1) begin : g_btb
      logic [DEPTH-1:0] valid_q;
      logic [1:0]       ctr_q [DEPTH];
      logic [TAG_W-1:0] tag_q [DEPTH];
      logic [XLEN-1:0]  tgt_q [DEPTH];

      logic [IDX_BITS-1:0] rd_idx, wr_idx;
      logic [TAG_W-1:0]    rd_tag, wr_tag;
      logic                rd_hit, wr_hit;
      logic                unused_if_lsb;

      assign rd_idx = if_pc[IDX_BITS+1:2];
      assign rd_tag = if_pc[XLEN-1:IDX_BITS+2];
      assign wr_idx = ex_pc[IDX_BITS+1:2];
      assign wr_tag = ex_pc[XLEN-1:IDX_BITS+2];
      assign unused_if_lsb = ^if_pc[1:0];

      // Reads see the array before this cycle's update lands on the edge.
      assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
      assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
      assign pred_target = pred_taken ? tgt_q[rd_idx] : '0;

      assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

      assign flush = ctl && ((ex_pred_taken != ex_taken) ||
                             (ex_taken && (ex_pred_target != ex_target)));
      assign bran_stall = 1'b0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'd0;
        end else if (ctl) begin
          if (wr_hit) begin
            ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], ex_taken);
          end else if (ex_taken) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= (ex_opcode == OP_BRANCH) ? 2'd2 : 2'd3;
          end
        end
      end

      // Tag/target are payload only; validity is carried by valid_q.
      always_ff @(posedge clk) begin
        if (!rst && ctl && (wr_hit || ex_taken)) begin
          tag_q[wr_idx] <= wr_tag;
          tgt_q[wr_idx] <= ex_target;
        end
      end
    end else begin : g_static
      logic unused_static;

      assign unused_static = ^{if_pc, ex_pred_taken, ex_pred_target};
      assign pred_taken    = 1'b0;
      assign pred_target   = '0;
      assign flush         = 1'b0;
      assign bran_stall    = ctl;
    end
  endgenerate

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: dynamic and static instances share EX/IF stimulus;
// directed vector table, counter/reset sequences, then random vs. a reference model.
module tb_branch_predictor;

  localparam logic [6:0] BR = 7'h63, JAL = 7'h6F, JALR = 7'h67, ALU = 7'h33, LD = 7'h03;

  logic        clk, rst;
  logic [31:0] if_pc, ex_pc, ex_target, ex_pred_target;
  logic        ex_valid, ex_taken, ex_pred_taken;
  logic [6:0]  ex_opcode;

  logic        d_pred, d_stall, d_flush;
  logic [31:0] d_ptgt, d_redir;
  logic [3:0]  d_bcnt, d_mcnt;
  logic        s_pred, s_stall, s_flush;
  logic [31:0] s_ptgt, s_redir;
  logic [3:0]  s_bcnt, s_mcnt;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .MODE(1), .CNT_W(4)) u_dyn (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(d_pred), .pred_target(d_ptgt),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .bran_stall(d_stall), .flush(d_flush), .redirect_pc(d_redir),
    .branch_cnt(d_bcnt), .mispred_cnt(d_mcnt));

  branch_predictor #(.XLEN(32), .IDX_BITS(6), .MODE(0), .CNT_W(4)) u_sta (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(s_pred), .pred_target(s_ptgt),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .bran_stall(s_stall), .flush(s_flush), .redirect_pc(s_redir),
    .branch_cnt(s_bcnt), .mispred_cnt(s_mcnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ifpc; logic v; logic [6:0] opc; logic [31:0] pc; logic tk;
    logic [31:0] tgt; logic pt; logic [31:0] ptg;
    logic e_pred; logic [31:0] e_ptgt; logic e_flush; logic [31:0] e_redir;
  } vec_t;

  vec_t vq[$];

  // Reference model state
  bit          m_v   [64];
  logic [31:0] m_pc  [64];
  logic [31:0] m_tgt [64];
  int          m_ctr [64];
  int          m_b, m_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ifpc, input logic v, input logic [6:0] opc,
                              input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic pt, input logic [31:0] ptg, input logic e_pred,
                              input logic [31:0] e_ptgt, input logic e_flush,
                              input logic [31:0] e_redir);
    vec_t r;
    r.ifpc = ifpc; r.v = v; r.opc = opc; r.pc = pc; r.tk = tk; r.tgt = tgt;
    r.pt = pt; r.ptg = ptg; r.e_pred = e_pred; r.e_ptgt = e_ptgt;
    r.e_flush = e_flush; r.e_redir = e_redir;
    return r;
  endfunction

  task automatic apply(input logic [31:0] ifpc, input logic v, input logic [6:0] opc,
                       input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg);
    if_pc = ifpc; ex_valid = v; ex_opcode = opc; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  function automatic bit is_ctl(input logic v, input logic [6:0] opc);
    return v && (opc == BR || opc == JAL || opc == JALR);
  endfunction

  function automatic int sat15(input int x);
    return (x >= 15) ? 15 : x + 1;
  endfunction

  task automatic model_pred(input logic [31:0] pc, output logic p, output logic [31:0] t);
    int i;
    i = int'((pc >> 2) % 64);
    p = m_v[i] && ((m_pc[i] >> 8) == (pc >> 8)) && (m_ctr[i] >= 2);
    t = p ? m_tgt[i] : 32'h0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 0; m_ctr[i] = 0; m_pc[i] = 0; m_tgt[i] = 0;
    end
    m_b = 0; m_m = 0;
  endtask

  task automatic model_update(input bit misp);
    int i;
    if (!is_ctl(ex_valid, ex_opcode)) return;
    i = int'((ex_pc >> 2) % 64);
    m_b = sat15(m_b);
    if (misp) m_m = sat15(m_m);
    if (m_v[i] && ((m_pc[i] >> 8) == (ex_pc >> 8))) begin
      m_tgt[i] = ex_target;
      if (ex_taken) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end else if (ex_taken) begin
      m_v[i] = 1; m_pc[i] = ex_pc; m_tgt[i] = ex_target;
      m_ctr[i] = (ex_opcode == BR) ? 2 : 3;
    end
  endtask

  task automatic static_checks();
    chk("s_stall", 32'(s_stall), 32'(is_ctl(ex_valid, ex_opcode)));
    chk("s_flush", 32'(s_flush), 32'h0);
    chk("s_pred", 32'(s_pred), 32'h0);
    chk("s_ptgt", s_ptgt, 32'h0);
    chk("d_stall", 32'(d_stall), 32'h0);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    apply(32'h0, 0, 7'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic        ep;
  logic [31:0] et;
  bit          misp;
  logic [6:0]  ops [5];

  initial begin
    ops[0] = BR; ops[1] = JAL; ops[2] = JALR; ops[3] = ALU; ops[4] = LD;
    rst = 1'b1;
    apply(32'h100, 0, 7'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    #12;
    chk("rst_pred", 32'(d_pred), 32'h0);
    chk("rst_ptgt", d_ptgt, 32'h0);
    chk("rst_flush", 32'(d_flush), 32'h0);
    chk("rst_s_stall", 32'(s_stall), 32'h0);
    chk("rst_bcnt", 32'(d_bcnt), 32'h0);
    chk("rst_mcnt", 32'(d_mcnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors: {if_pc, valid, opc, ex_pc, taken, tgt, pt, ptg, exp pred, exp ptgt, exp flush, exp redirect}
    vq.push_back(mk(32'h100, 1, BR,   32'h100, 1, 32'h80,  0, 32'h0,   0, 32'h0,   1, 32'h80));
    vq.push_back(mk(32'h100, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0));
    vq.push_back(mk(32'h100, 1, BR,   32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104));
    vq.push_back(mk(32'h100, 1, BR,   32'h100, 0, 32'h80,  0, 32'h0,   0, 32'h0,   0, 32'h0));
    vq.push_back(mk(32'h100, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
    vq.push_back(mk(32'h200, 1, JAL,  32'h200, 1, 32'h400, 0, 32'h0,   0, 32'h0,   1, 32'h400));
    vq.push_back(mk(32'h200, 1, JAL,  32'h200, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h0));
    vq.push_back(mk(32'h200, 1, JAL,  32'h200, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h0));
    vq.push_back(mk(32'h200, 1, JAL,  32'h200, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h0));
    vq.push_back(mk(32'h200, 1, JAL,  32'h200, 1, 32'h400, 1, 32'h404, 1, 32'h400, 1, 32'h400));
    vq.push_back(mk(32'h100, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
    vq.push_back(mk(32'h200, 1, BR,   32'h100, 1, 32'h80,  0, 32'h0,   1, 32'h400, 1, 32'h80));
    vq.push_back(mk(32'h200, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
    vq.push_back(mk(32'h100, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0));
    vq.push_back(mk(32'h100, 1, BR,   32'h200, 1, 32'h300, 0, 32'h0,   1, 32'h80,  1, 32'h300));
    vq.push_back(mk(32'h100, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 32'h0));
    vq.push_back(mk(32'h200, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0));
    vq.push_back(mk(32'h200, 0, BR,   32'h200, 0, 32'h300, 1, 32'h300, 1, 32'h300, 0, 32'h0));
    vq.push_back(mk(32'h200, 1, ALU,  32'h200, 0, 32'h300, 1, 32'h300, 1, 32'h300, 0, 32'h0));
    vq.push_back(mk(32'h200, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0));
    vq.push_back(mk(32'h500, 1, JALR, 32'h500, 1, 32'h600, 0, 32'h0,   0, 32'h0,   1, 32'h600));
    vq.push_back(mk(32'h500, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h600, 0, 32'h0));
    vq.push_back(mk(32'h500, 1, JALR, 32'h500, 0, 32'h600, 1, 32'h600, 1, 32'h600, 1, 32'h504));
    vq.push_back(mk(32'h500, 0, 7'h0, 32'h0,   0, 32'h0,   0, 32'h0,   1, 32'h600, 0, 32'h0));

    foreach (vq[k]) begin
      apply(vq[k].ifpc, vq[k].v, vq[k].opc, vq[k].pc, vq[k].tk, vq[k].tgt, vq[k].pt, vq[k].ptg);
      #4;
      chk($sformatf("vec%0d_pred", k), 32'(d_pred), 32'(vq[k].e_pred));
      chk($sformatf("vec%0d_ptgt", k), d_ptgt, vq[k].e_ptgt);
      chk($sformatf("vec%0d_flush", k), 32'(d_flush), 32'(vq[k].e_flush));
      if (vq[k].e_flush) chk($sformatf("vec%0d_redir", k), d_redir, vq[k].e_redir);
      static_checks();
      @(posedge clk); #1;
    end
    chk("tbl_bcnt", 32'(d_bcnt), 32'd12);
    chk("tbl_mcnt", 32'(d_mcnt), 32'd8);
    chk("tbl_s_bcnt", 32'(s_bcnt), 32'd12);
    chk("tbl_s_mcnt", 32'(s_mcnt), 32'd0);

    // Counter saturation with 4-bit counters
    sync_reset();
    for (int i = 0; i < 20; i++) begin
      apply(32'h1000, 1, BR, 32'h1000, 1, 32'h2000, 0, 32'h0);
      @(posedge clk); #1;
      if (i == 13) begin
        chk("sat14_bcnt", 32'(d_bcnt), 32'd14);
        chk("sat14_mcnt", 32'(d_mcnt), 32'd14);
      end
    end
    chk("sat_bcnt", 32'(d_bcnt), 32'd15);
    chk("sat_mcnt", 32'(d_mcnt), 32'd15);
    chk("sat_s_bcnt", 32'(s_bcnt), 32'd15);
    apply(32'h1000, 0, 7'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    #2;
    chk("pre_arst_pred", 32'(d_pred), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_bcnt", 32'(d_bcnt), 32'h0);
    chk("arst_mcnt", 32'(d_mcnt), 32'h0);
    chk("arst_pred", 32'(d_pred), 32'h0);
    chk("arst_ptgt", d_ptgt, 32'h0);
    // Update presented while reset is held across an edge must be discarded
    apply(32'h1000, 1, BR, 32'h1000, 1, 32'h2000, 0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply(32'h1000, 0, 7'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    #4;
    chk("rsthold_pred", 32'(d_pred), 32'h0);
    chk("rsthold_bcnt", 32'(d_bcnt), 32'h0);
    @(posedge clk); #1;

    // Random phase against the reference model
    sync_reset();
    model_clear();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc, rif, rtgt, rptg;
      logic rv, rtk, rpt;
      logic [6:0] rop;
      rpc  = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
      rif  = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2));
      rtgt = 32'($urandom_range(0, 15) << 4);
      rv   = ($urandom_range(0, 9) < 8);
      rop  = ops[$urandom_range(0, 4)];
      rtk  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        model_pred(rpc, rpt, rptg);
      end else begin
        rpt  = 1'($urandom_range(0, 1));
        rptg = 32'($urandom_range(0, 15) << 4);
      end
      apply(rif, rv, rop, rpc, rtk, rtgt, rpt, rptg);
      #4;
      model_pred(if_pc, ep, et);
      misp = is_ctl(ex_valid, ex_opcode) &&
             ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
      chk("rnd_pred", 32'(d_pred), 32'(ep));
      chk("rnd_ptgt", d_ptgt, et);
      chk("rnd_flush", 32'(d_flush), 32'(misp));
      if (misp) chk("rnd_redir", d_redir, ex_taken ? ex_target : ex_pc + 32'd4);
      static_checks();
      @(posedge clk); #1;
      model_update(misp);
      chk("rnd_bcnt", 32'(d_bcnt), 32'(m_b));
      chk("rnd_mcnt", 32'(d_mcnt), 32'(m_m));
      chk("rnd_s_bcnt", 32'(s_bcnt), 32'(m_b));
      chk("rnd_s_mcnt", 32'(s_mcnt), 32'h0);
      if (n == 300) begin
        sync_reset();
        model_clear();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
